// File: rtl/vga_ctrl_if.sv
// Display timing bundle from the VGA sequencer to the layer generators, mixer and DAC.
// The master side drives the bundle. The slave side observes it.
interface vga_ctrl_if;
   logic       vga_clk;
   logic       pix_en;
   logic [9:0] x;
   logic [9:0] y;
   logic       hs;
   logic       vs;
   logic       blank;
   logic       frame_start;

   modport master (
      output vga_clk, pix_en, x, y, hs, vs, blank, frame_start
   );

   modport slave (
      input vga_clk, pix_en, x, y, hs, vs, blank, frame_start
   );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing sequencer. A half-rate pixel strobe advances the x/y counters. The sync and blank
// decodes pass through a PIPE_LAT-deep delay line so that they stay aligned with the layer pipeline.
module vga_ctrl #(
   parameter int H_DISP   = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_DISP   = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   vga_ctrl_if.master   vga
);
   localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS   = 10'(H_DISP);
   localparam logic [9:0] V_VIS   = 10'(V_DISP);
   localparam logic [9:0] HS_ON   = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_OFF  = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] VS_ON   = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_OFF  = 10'(V_DISP + V_FP + V_SYNC);
   localparam logic [9:0] FS_LINE = 10'(V_DISP - 1);

   logic                phase;
   logic                vga_clk_q;
   logic                frame_start_q;
   logic [9:0]          x_q;
   logic [9:0]          y_q;
   logic [PIPE_LAT-1:0] hs_pipe;
   logic [PIPE_LAT-1:0] vs_pipe;
   logic [PIPE_LAT-1:0] blank_pipe;
   logic                last_col;
   logic                hs_raw;
   logic                vs_raw;
   logic                blank_raw;

   always_comb begin
      last_col  = (x_q == H_LAST);
      blank_raw = (x_q < H_VIS) && (y_q < V_VIS);
      hs_raw    = !((x_q >= HS_ON) && (x_q < HS_OFF));
      vs_raw    = !((y_q >= VS_ON) && (y_q < VS_OFF));
   end

   // The phase bit doubles as the pixel strobe. vga_clk lags it by one clk, so the
   // DAC samples in the middle of a pixel rather than on an x/y change.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase         <= 1'b0;
         vga_clk_q     <= 1'b0;
         frame_start_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
      end else begin
         phase         <= ~phase;
         vga_clk_q     <= phase;
         frame_start_q <= phase && last_col && (y_q == FS_LINE);
         if (phase) begin
            if (last_col) begin
               x_q <= '0;
               y_q <= (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
               x_q <= x_q + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hs_pipe    <= '1;
         vs_pipe    <= '1;
         blank_pipe <= '0;
      end else if (phase) begin
         hs_pipe[0]    <= hs_raw;
         vs_pipe[0]    <= vs_raw;
         blank_pipe[0] <= blank_raw;
         for (int i = 1; i < PIPE_LAT; i++) begin
            hs_pipe[i]    <= hs_pipe[i-1];
            vs_pipe[i]    <= vs_pipe[i-1];
            blank_pipe[i] <= blank_pipe[i-1];
         end
      end
   end

   assign vga.vga_clk     = vga_clk_q;
   assign vga.pix_en      = phase;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.hs          = hs_pipe[PIPE_LAT-1];
   assign vga.vs          = vs_pipe[PIPE_LAT-1];
   assign vga.blank       = blank_pipe[PIPE_LAT-1];
   assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a default-timing instance and a tiny-timing instance (PIPE_LAT=1) run side by side.
// A behavioural model queues the expected sync/blank outputs at each pixel strobe and releases them PIPE_LAT strobes later.
module tb_vga_ctrl;
   logic clk     = 1'b0;
   logic rst_d_n = 1'b0;
   logic rst_s_n = 1'b0;

   int total = 0;
   int bad   = 0;

   int         mx[2];
   int         my[2];
   logic       mph[2];
   logic       mvc[2];
   logic       mfs[2];
   logic [2:0] eo[2];
   logic [2:0] qd[$];
   logic [2:0] qs[$];

   localparam logic [25:0] RST_VAL = {10'd0, 10'd0, 1'b0, 1'b0, 3'b110, 1'b0};

   vga_ctrl_if bus_d();
   vga_ctrl_if bus_s();

   vga_ctrl dut_d (
      .clk     (clk),
      .reset_n (rst_d_n),
      .vga     (bus_d)
   );

   vga_ctrl #(
      .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .PIPE_LAT(1)
   ) dut_s (
      .clk     (clk),
      .reset_n (rst_s_n),
      .vga     (bus_s)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] raw(int k, int px, int py);
      logic b, h, v;
      if (k == 0) begin
         b = (px < 640) && (py < 480);
         h = !((px >= 656) && (px < 752));
         v = !((py >= 490) && (py < 492));
      end else begin
         b = (px < 8) && (py < 4);
         h = !((px >= 10) && (px < 13));
         v = !((py >= 5) && (py < 6));
      end
      return {h, v, b};
   endfunction

   task automatic step(int k, logic rn);
      int ht = (k == 0) ? 800 : 15;
      int vt = (k == 0) ? 525 : 7;
      int vd = (k == 0) ? 480 : 4;
      int lat = (k == 0) ? 2 : 1;
      logic [2:0] r;
      if (!rn) begin
         mph[k] = 1'b0; mvc[k] = 1'b0; mfs[k] = 1'b0;
         mx[k] = 0; my[k] = 0; eo[k] = 3'b110;
         if (k == 0) begin
            qd.delete();
            for (int i = 1; i < lat; i++) qd.push_back(3'b110);
         end else begin
            qs.delete();
            for (int i = 1; i < lat; i++) qs.push_back(3'b110);
         end
      end else begin
         mvc[k] = mph[k];
         mfs[k] = mph[k] && (mx[k] == ht - 1) && (my[k] == vd - 1);
         if (mph[k]) begin
            r = raw(k, mx[k], my[k]);
            if (k == 0) begin
               qd.push_back(r);
               eo[k] = qd.pop_front();
            end else begin
               qs.push_back(r);
               eo[k] = qs.pop_front();
            end
            if (mx[k] == ht - 1) begin
               mx[k] = 0;
               my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
            end else begin
               mx[k] = mx[k] + 1;
            end
         end
         mph[k] = !mph[k];
      end
   endtask

   always @(posedge clk) begin
      step(0, rst_d_n);
      step(1, rst_s_n);
   end

   function automatic logic [25:0] obs(int k);
      if (k == 0)
         return {bus_d.x, bus_d.y, bus_d.pix_en, bus_d.vga_clk, bus_d.hs, bus_d.vs, bus_d.blank, bus_d.frame_start};
      return {bus_s.x, bus_s.y, bus_s.pix_en, bus_s.vga_clk, bus_s.hs, bus_s.vs, bus_s.blank, bus_s.frame_start};
   endfunction

   function automatic logic [25:0] expv(int k);
      return {10'(mx[k]), 10'(my[k]), mph[k], mvc[k], eo[k], mfs[k]};
   endfunction

   // Called on a negedge; returns on the negedge just after the third reset edge, with reset released.
   task automatic do_reset(int k);
      if (k == 0) rst_d_n = 1'b0; else rst_s_n = 1'b0;
      repeat (3) @(negedge clk);
      if (k == 0) rst_d_n = 1'b1; else rst_s_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] want;
      rst_d_n = 1'b0;
      rst_s_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs(k) !== RST_VAL) begin
            bad++;
            $display("[TB] FAIL reset_hold dut=%0d got=%h want=%h", k, obs(k), RST_VAL);
         end
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs(k) !== RST_VAL) begin
            bad++;
            $display("[TB] FAIL reset_release dut=%0d got=%h want=%h", k, obs(k), RST_VAL);
         end
      end
      rst_d_n = 1'b1;
      rst_s_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         want = {10'(i / 2), (i % 2) == 1, (i % 2) == 0, i >= 4};
         total++;
         if ({bus_d.x, bus_d.pix_en, bus_d.vga_clk, bus_d.blank} !== want) begin
            bad++;
            $display("[TB] FAIL reset_seq i=%0d got=%h want=%h", i, {bus_d.x, bus_d.pix_en, bus_d.vga_clk, bus_d.blank}, want);
         end
         total++;
         if (bus_s.blank !== (i >= 2)) begin
            bad++;
            $display("[TB] FAIL reset_seq_small i=%0d got=%b want=%b", i, bus_s.blank, i >= 2);
         end
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== expv(k)) begin
               bad++;
               $display("[TB] FAIL reset_sb dut=%0d i=%0d got=%h want=%h", k, i, obs(k), expv(k));
            end
         end
      end
   endtask

   task automatic test_line_timing();
      int t_blank = -1;
      int t_x656 = -1;
      int t_hs = -1;
      int blank_cnt = 0;
      int hs_cnt = 0;
      do_reset(0);
      for (int t = 0; t <= 3200; t++) begin
         total++;
         if (obs(0) !== expv(0)) begin
            bad++;
            $display("[TB] FAIL line_sb t=%0d got=%h want=%h", t, obs(0), expv(0));
         end
         if (t_blank < 0 && bus_d.blank === 1'b1) t_blank = t;
         if (t_x656 < 0 && bus_d.x === 10'd656) t_x656 = t;
         if (t_hs < 0 && bus_d.hs === 1'b0) t_hs = t;
         if (t < 1600 && bus_d.pix_en === 1'b1) begin
            if (bus_d.blank === 1'b1) blank_cnt++;
            if (bus_d.hs === 1'b0) hs_cnt++;
         end
         if (t == 1600 || t == 3200) begin
            total++;
            if ({bus_d.x, bus_d.y} !== {10'd0, 10'(t / 1600)}) begin
               bad++;
               $display("[TB] FAIL line_wrap t=%0d got=%0d,%0d want=0,%0d", t, bus_d.x, bus_d.y, t / 1600);
            end
         end
         if (t < 3200) @(negedge clk);
      end
      total++;
      if (t_blank != 4) begin bad++; $display("[TB] FAIL blank_rise got=%0d want=4", t_blank); end
      total++;
      if (blank_cnt != 640) begin bad++; $display("[TB] FAIL blank_width got=%0d want=640", blank_cnt); end
      total++;
      if (t_x656 != 1312) begin bad++; $display("[TB] FAIL x656_time got=%0d want=1312", t_x656); end
      total++;
      if (t_hs - t_x656 != 4) begin bad++; $display("[TB] FAIL hs_delay got=%0d want=4", t_hs - t_x656); end
      total++;
      if (hs_cnt != 96) begin bad++; $display("[TB] FAIL hs_width got=%0d want=96", hs_cnt); end
   endtask

   task automatic test_frame_small();
      int t_fs = -1;
      int fs_cnt = 0;
      int vs_cnt = 0;
      int hs_cnt = 0;
      int t_x10 = -1;
      int t_hs = -1;
      do_reset(1);
      for (int t = 0; t <= 420; t++) begin
         total++;
         if (obs(1) !== expv(1)) begin
            bad++;
            $display("[TB] FAIL frame_sb t=%0d got=%h want=%h", t, obs(1), expv(1));
         end
         if (bus_s.frame_start === 1'b1) begin
            fs_cnt++;
            if (t_fs < 0) t_fs = t;
            total++;
            if ({bus_s.x, bus_s.y} !== {10'd0, 10'd4}) begin
               bad++;
               $display("[TB] FAIL fs_pos t=%0d got=%0d,%0d want=0,4", t, bus_s.x, bus_s.y);
            end
         end
         if (t_x10 < 0 && bus_s.x === 10'd10) t_x10 = t;
         if (t_hs < 0 && bus_s.hs === 1'b0) t_hs = t;
         if (bus_s.pix_en === 1'b1 && t < 210 && bus_s.vs === 1'b0) vs_cnt++;
         if (bus_s.pix_en === 1'b1 && t < 30 && bus_s.hs === 1'b0) hs_cnt++;
         if (t == 209 || t == 210) begin
            total++;
            if ({bus_s.x, bus_s.y} !== ((t == 209) ? {10'd14, 10'd6} : {10'd0, 10'd0})) begin
               bad++;
               $display("[TB] FAIL frame_wrap t=%0d got=%0d,%0d", t, bus_s.x, bus_s.y);
            end
         end
         if (t < 420) @(negedge clk);
      end
      total++;
      if (fs_cnt != 2) begin bad++; $display("[TB] FAIL fs_count got=%0d want=2", fs_cnt); end
      total++;
      if (t_fs != 120) begin bad++; $display("[TB] FAIL fs_time got=%0d want=120", t_fs); end
      total++;
      if (vs_cnt != 15) begin bad++; $display("[TB] FAIL vs_width got=%0d want=15", vs_cnt); end
      total++;
      if (hs_cnt != 3) begin bad++; $display("[TB] FAIL hs_small_width got=%0d want=3", hs_cnt); end
      total++;
      if (t_hs - t_x10 != 2) begin bad++; $display("[TB] FAIL hs_small_delay got=%0d want=2", t_hs - t_x10); end
   endtask

   task automatic test_midframe_reset(int k);
      int ty = (k == 0) ? 1 : 5;
      int tx = (k == 0) ? 700 : 11;
      int limit = (k == 0) ? 4000 : 300;
      int t_blank = -1;
      logic [1:0] sync_want = (k == 0) ? 2'b01 : 2'b00;
      logic [25:0] o;
      bit found = 0;
      do_reset(k);
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         o = obs(k);
         if (o[25:16] == 10'(tx) && o[15:6] == 10'(ty) && o[5] === 1'b0) found = 1;
      end
      total++;
      if (!found) begin bad++; $display("[TB] FAIL mid_reach dut=%0d got=%h want_xy=%0d,%0d", k, obs(k), tx, ty); end
      total++;
      if (obs(k) !== expv(k)) begin bad++; $display("[TB] FAIL mid_pre dut=%0d got=%h want=%h", k, obs(k), expv(k)); end
      o = obs(k);
      total++;
      if (o[3:2] !== sync_want) begin bad++; $display("[TB] FAIL mid_sync dut=%0d got=%b want=%b", k, o[3:2], sync_want); end
      if (k == 0) rst_d_n = 1'b0; else rst_s_n = 1'b0;
      @(negedge clk);
      total++;
      if (obs(k) !== RST_VAL) begin bad++; $display("[TB] FAIL mid_reset dut=%0d got=%h want=%h", k, obs(k), RST_VAL); end
      if (k == 0) rst_d_n = 1'b1; else rst_s_n = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         o = obs(k);
         if (t_blank < 0 && o[1] === 1'b1) t_blank = t;
         total++;
         if (o !== expv(k)) begin
            bad++;
            $display("[TB] FAIL mid_sb dut=%0d t=%0d got=%h want=%h", k, t, o, expv(k));
         end
      end
      total++;
      if (t_blank != ((k == 0) ? 4 : 2)) begin
         bad++;
         $display("[TB] FAIL mid_blank_rise dut=%0d got=%0d want=%0d", k, t_blank, (k == 0) ? 4 : 2);
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_small();
      test_midframe_reset(0);
      test_midframe_reset(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- Display timing sequencer for the VGA output path.
- Derives a pixel-rate enable from the system clock and runs horizontal and vertical pixel counters.
- Outputs the pixel coordinates that the layer generators (background, sprites) use to compute colour.
- Outputs `hs`, `vs` and `blank`, delayed to line up with the layer pipeline latency. `blank` drives the mixer directly and `hs`/`vs` drive the DAC/connector.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 2, layer pipeline latency in pixel periods (>=1); delay applied to hs/vs/blank

Ports:
- clk  in  1  system clock (50 MHz nominal)
- reset_n  in  1  synchronous reset, active low
- vga_clk  out  1  pixel clock to DAC (clk/2)
- pix_en  out  1  one-clk strobe, one per pixel period
- x  out  10  current horizontal count, 0..H_TOT-1
- y  out  10  current vertical count, 0..V_TOT-1
- hs  out  1  horizontal sync, active low, delayed PIPE_LAT
- vs  out  1  vertical sync, active low, delayed PIPE_LAT
- blank  out  1  1 = active video (mixer passes colour), 0 = force black; delayed PIPE_LAT
- frame_start  out  1  one-clk pulse at start of vertical blanking (game-logic update tick)

Behaviour:
- One clock; reset is synchronous and active-low. All state is sampled on the rising edge of `clk`; `reset_n` is only sampled there.
- Derived constants:
  - H_TOT = H_DISP+H_FP+H_SYNC+H_BP (800).
  - V_TOT = V_DISP+V_FP+V_SYNC+V_BP (525).
- Reset values (reset_n=0 at an edge), all forced the next cycle:
  - phase bit = 0, pix_en = 0, vga_clk = 0.
  - x = 0, y = 0.
  - hs = 1, vs = 1, blank = 0, frame_start = 0.
  - Every delay-stage register holds the inactive values hs=1, vs=1, blank=0.
- Reset mid-frame has the same effect: counters return to 0,0 immediately and no partial sync pulse is extended.
- Pixel enable:
  - The phase bit toggles every clk after reset.
  - pix_en = 1 in the cycle where phase = 1, so the first pix_en occurs on the second cycle after reset release.
  - vga_clk is a registered copy of phase, so its rising edge falls mid-pixel relative to x/y updates.
- Counters advance only on a cycle with pix_en = 1:
  - x increments; at x = H_TOT-1, x wraps to 0 and y increments.
  - At x = H_TOT-1 and y = V_TOT-1, both wrap to 0.
  - x and y are registered outputs, undelayed. A pixel period is two clk cycles; x/y are stable for both.
- Raw decode, combinational from the current x/y:
  - blank_raw = (x < H_DISP) && (y < V_DISP).
  - hs_raw = !((x >= H_DISP+H_FP) && (x < H_DISP+H_FP+H_SYNC)).
  - vs_raw = !((y >= V_DISP+V_FP) && (y < V_DISP+V_FP+V_SYNC)).
- Delay line:
  - PIPE_LAT register stages, each advancing only on pix_en.
  - Stage 0 captures the raw values; outputs come from stage PIPE_LAT-1.
  - Net effect: outputs for pixel (x,y) appear exactly PIPE_LAT pixel periods after x/y show (x,y).
  - Outputs hold between pix_en strobes.
- frame_start:
  - High for exactly one clk.
  - Asserted in the cycle after the pix_en that moves the counters to x = 0, y = V_DISP.
  - Undelayed, and not asserted on the wrap to y = 0.
- Widths: 10 bits covers H_TOT and V_TOT up to 1023. Parameter sets beyond that are unsupported; no saturation logic is required.
- No other inputs. Counting is free-running and never stalls.

Test Plan:
- Reset: hold reset_n=0 for 3 clk, release. Then:
  - x=0, y=0, hs=1, vs=1, blank=0, vga_clk=0.
  - First pix_en on the 2nd clk after release.
  - pix_en thereafter every 2 clk.
- Active start: after reset release, blank rises PIPE_LAT=2 pixel periods (4 clk) after the first displayed (0,0) slot. blank stays high for exactly 640 pix_en strobes, then falls.
- Line timing:
  - hs falls 2 pixel periods after x reaches 656.
  - hs stays low for exactly 96 pix_en strobes (192 clk).
  - Line period is 800 pix_en strobes; on x 799→0, y increments by 1.
- Frame timing:
  - y wraps 524→0 together with x 799→0.
  - vs is low for exactly 2 lines (1600 pix_en), starting 2 pixel periods after (0,490).
  - frame_start pulses once per 420000 pix_en, 1 clk wide, at (0,480).
- Mid-frame reset at y=300, x=123: the next clk shows x=0, y=0, hs=vs=1, blank=0. The following frame's timing is identical to the post-power-up case.
- Parameter override with H_DISP=8, H_FP=2, H_SYNC=3, H_BP=2, V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1, PIPE_LAT=1:
  - Line period 15 pixels, frame period 7 lines.
  - hs low for x 10..12 (shifted by 1 pixel).
  - frame_start at (0,4).
